// File: rtl/fx_reg_slave_if.sv
// fx bus bundle: single-cycle write and read strobes with registered read data.
interface fx_reg_slave_if;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;

  modport master (
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    input  fx_q
  );

  modport slave (
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    output fx_q
  );
endinterface

// File: rtl/fx_reg_slave.sv
// Register-bank slave on the fx bus: ID/scratch/control/mask/pulse registers,
// sticky event flags with interrupt, and a microsecond timer whose upper bytes
// are captured into a shadow when the low byte is read.
module fx_reg_slave #(
  parameter logic [21:0] BASE_ADDR = 22'h000100,
  parameter logic [7:0]  ID_VAL    = 8'h5A
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         pluse_us,
  fx_reg_slave_if.slave bus,
  input  logic [7:0]   evt_in,
  output logic [7:0]   ctrl_out,
  output logic [7:0]   pulse_out,
  output logic         irq
);

  localparam logic [3:0] OFF_ID    = 4'h0;
  localparam logic [3:0] OFF_SCR   = 4'h1;
  localparam logic [3:0] OFF_CTRL  = 4'h2;
  localparam logic [3:0] OFF_STAT  = 4'h3;
  localparam logic [3:0] OFF_TIM0  = 4'h4;
  localparam logic [3:0] OFF_TIM1  = 4'h5;
  localparam logic [3:0] OFF_TIM2  = 4'h6;
  localparam logic [3:0] OFF_TIM3  = 4'h7;
  localparam logic [3:0] OFF_PULSE = 4'h8;
  localparam logic [3:0] OFF_MASK  = 4'h9;

  logic [7:0]  scr;
  logic [7:0]  ctrl;
  logic [7:0]  stat;
  logic [7:0]  mask;
  logic [31:0] timer;
  logic [23:0] shadow;
  logic [7:0]  rd_data;

  logic       wr_hit;
  logic       rd_hit;
  logic [3:0] wr_off;
  logic [3:0] rd_off;
  logic [7:0] stat_clr;
  logic       tim_clr;
  logic       tim_snap;

  assign wr_hit   = bus.fx_wr && (bus.fx_waddr[21:4] == BASE_ADDR[21:4]);
  assign rd_hit   = bus.fx_rd && (bus.fx_raddr[21:4] == BASE_ADDR[21:4]);
  assign wr_off   = bus.fx_waddr[3:0];
  assign rd_off   = bus.fx_raddr[3:0];
  assign stat_clr = (wr_hit && wr_off == OFF_STAT) ? bus.fx_data : 8'h00;
  assign tim_clr  = wr_hit && (wr_off == OFF_TIM0);
  assign tim_snap = rd_hit && (rd_off == OFF_TIM0);
  assign ctrl_out = ctrl;

  // Read mux over current (pre-edge) register values; reserved offsets read 0.
  always_comb begin
    rd_data = 8'h00;
    case (rd_off)
      OFF_ID:   rd_data = ID_VAL;
      OFF_SCR:  rd_data = scr;
      OFF_CTRL: rd_data = ctrl;
      OFF_STAT: rd_data = stat;
      OFF_TIM0: rd_data = timer[7:0];
      OFF_TIM1: rd_data = shadow[7:0];
      OFF_TIM2: rd_data = shadow[15:8];
      OFF_TIM3: rd_data = shadow[23:16];
      OFF_MASK: rd_data = mask;
      default:  rd_data = 8'h00;
    endcase
  end

  // Plain read/write registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      scr  <= 8'h00;
      ctrl <= 8'h00;
      mask <= 8'h00;
    end else if (wr_hit) begin
      if (wr_off == OFF_SCR)  scr  <= bus.fx_data;
      if (wr_off == OFF_CTRL) ctrl <= bus.fx_data;
      if (wr_off == OFF_MASK) mask <= bus.fx_data;
    end
  end

  // Sticky event flags: a new event wins over a same-cycle W1C clear.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) stat <= 8'h00;
    else        stat <= (stat & ~stat_clr) | evt_in;
  end

  // Microsecond timer; a write to TIM0 clears it and overrides a tick.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)        timer <= 32'h0;
    else if (tim_clr)  timer <= 32'h0;
    else if (pluse_us) timer <= timer + 32'h1;
  end

  // Shadow of the upper timer bytes, captured with the TIM0 read so the
  // four bytes form one coherent sample.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)        shadow <= 24'h0;
    else if (tim_snap) shadow <= timer[31:8];
  end

  // Registered read data; a miss returns 0 so slaves can be OR-combined.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)          bus.fx_q <= 8'h00;
    else if (bus.fx_rd)  bus.fx_q <= rd_hit ? rd_data : 8'h00;
  end

  // One-cycle strobes from PULSE writes, and the registered interrupt.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pulse_out <= 8'h00;
      irq       <= 1'b0;
    end else begin
      pulse_out <= (wr_hit && wr_off == OFF_PULSE) ? bus.fx_data : 8'h00;
      irq       <= |(stat & mask);
    end
  end

endmodule
